vdp_vram_arb: RTL and testbench

VRAM access arbiter for the TMS9918A-compatible VDP, sitting directly upstream of the 3-cycle SRAM controller. Merges two requesters onto the single controller request port: the display fetch engine and the CPU data port. The CPU port has a TMS9918-style auto-incrementing address register, a write-data holding register and a read-ahead latch. Display fetch has priority; the CPU is serviced in idle slots.

---
 rtl/vdp_arb_pkg.sv | 15 +
 rtl/vdp_vram_arb_if.sv | 22 ++
 rtl/vdp_cpu_port.sv | 65 ++++++
 rtl/vdp_vram_arb.sv | 119 +++++++++++
 tb/tb_vdp_vram_arb.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_arb_pkg.sv
// Shared types and sizing for the VDP VRAM arbiter slice.
package vdp_arb_pkg;

  localparam int unsigned VRAM_AW       = 14;
  localparam int unsigned VRAM_DW       = 8;
  localparam int unsigned ACCESS_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPT
  } arb_state_t;

endpackage

// File: rtl/vdp_vram_arb_if.sv
// Request/ack bus between the VRAM arbiter (master) and the SRAM controller (slave).
interface vdp_vram_arb_if;
  import vdp_arb_pkg::*;

  logic               vram_req;
  logic               vram_wr;
  logic [VRAM_AW-1:0] vram_addr;
  logic [VRAM_DW-1:0] vram_wdata;
  logic               vram_ack;
  logic [VRAM_DW-1:0] vram_rdata;

  modport master (
    output vram_req, vram_wr, vram_addr, vram_wdata,
    input  vram_ack, vram_rdata
  );

  modport slave (
    input  vram_req, vram_wr, vram_addr, vram_wdata,
    output vram_ack, vram_rdata
  );

endinterface

// File: rtl/vdp_cpu_port.sv
// CPU side of the arbiter: auto-incrementing address register, write holding
// register, read-ahead latch, and the pending/overrun flags.
module vdp_cpu_port
  import vdp_arb_pkg::*;
(
  input  logic               clk40m,
  input  logic               rst_n,
  input  logic               cpu_addr_ld,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic               cpu_rd_ahead,
  input  logic               cpu_data_wr,
  input  logic [VRAM_DW-1:0] cpu_wdata,
  input  logic               cpu_data_rd,
  output logic [VRAM_DW-1:0] cpu_rdata,
  output logic               cpu_busy,
  output logic               cpu_overrun,
  output logic               pend,
  output logic [VRAM_AW-1:0] addr,
  output logic               wr,
  output logic [VRAM_DW-1:0] wdata,
  input  logic               done,
  input  logic [VRAM_DW-1:0] rdata
);

  logic strobe;

  assign strobe   = cpu_addr_ld | cpu_data_wr | cpu_data_rd;
  assign cpu_busy = pend;

  // pend stays set through the whole access so busy covers queue and flight;
  // done can only arrive while pend is set, so strobes then only flag overrun.
  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      wdata       <= '0;
      cpu_rdata   <= '0;
      pend        <= 1'b0;
      wr          <= 1'b0;
      cpu_overrun <= 1'b0;
    end else begin
      if (done) begin
        pend <= 1'b0;
        addr <= addr + VRAM_AW'(1);
        if (!wr) cpu_rdata <= rdata;
      end
      if (strobe) begin
        if (pend) begin
          cpu_overrun <= 1'b1;
        end else if (cpu_addr_ld) begin
          addr <= cpu_addr;
          pend <= cpu_rd_ahead;
          wr   <= 1'b0;
        end else if (cpu_data_wr) begin
          wdata <= cpu_wdata;
          pend  <= 1'b1;
          wr    <= 1'b1;
        end else begin
          pend <= 1'b1;
          wr   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/vdp_vram_arb.sv
// VRAM arbiter: display fetch has priority, CPU port fills idle slots.
// Optional display/CPU fairness bound enabled by VDP_ARB_FAIR_EN.
module vdp_vram_arb
  import vdp_arb_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = 3
) (
  input  logic               clk40m,
  input  logic               rst_n,
  input  logic               disp_req,
  input  logic [VRAM_AW-1:0] disp_addr,
  output logic               disp_ack,
  output logic [VRAM_DW-1:0] disp_rdata,
  input  logic               cpu_addr_ld,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic               cpu_rd_ahead,
  input  logic               cpu_data_wr,
  input  logic [VRAM_DW-1:0] cpu_wdata,
  input  logic               cpu_data_rd,
  output logic [VRAM_DW-1:0] cpu_rdata,
  output logic               cpu_busy,
  output logic               cpu_overrun,
  vdp_vram_arb_if.master     vram
);

  arb_state_t         state_q, state_d;
  logic               owner_cpu_q;
  logic               grant_disp, grant_cpu;
  logic               capt, cpu_done, disp_done;
  logic               cpu_elig, fair_hit;
  logic               p_pend, p_wr;
  logic [VRAM_AW-1:0] p_addr;
  logic [VRAM_DW-1:0] p_wdata;
  logic [VRAM_DW-1:0] disp_rdata_q;

  vdp_cpu_port u_cpu_port (
    .clk40m       (clk40m),
    .rst_n        (rst_n),
    .cpu_addr_ld  (cpu_addr_ld),
    .cpu_addr     (cpu_addr),
    .cpu_rd_ahead (cpu_rd_ahead),
    .cpu_data_wr  (cpu_data_wr),
    .cpu_wdata    (cpu_wdata),
    .cpu_data_rd  (cpu_data_rd),
    .cpu_rdata    (cpu_rdata),
    .cpu_busy     (cpu_busy),
    .cpu_overrun  (cpu_overrun),
    .pend         (p_pend),
    .addr         (p_addr),
    .wr           (p_wr),
    .wdata        (p_wdata),
    .done         (cpu_done),
    .rdata        (vram.vram_rdata)
  );

  assign capt      = (state_q == ST_CAPT);
  assign cpu_done  = capt & owner_cpu_q;
  assign disp_done = capt & ~owner_cpu_q;
  // The CPU op being captured this cycle is still flagged pending; exclude it.
  assign cpu_elig  = p_pend & ~cpu_done;

`ifdef VDP_ARB_FAIR_EN
  localparam int unsigned FCW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  logic [FCW-1:0] fair_cnt;

  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n)
      fair_cnt <= '0;
    else if (grant_cpu || !cpu_elig)
      fair_cnt <= '0;
    else if (grant_disp && (fair_cnt != FCW'(FAIR_LIMIT)))
      fair_cnt <= fair_cnt + FCW'(1);
  end

  assign fair_hit = (fair_cnt == FCW'(FAIR_LIMIT));
`else
  assign fair_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_disp = 1'b0;
    grant_cpu  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_CAPT: begin
        if (disp_req && !(fair_hit && cpu_elig))
          grant_disp = 1'b1;
        else if (cpu_elig)
          grant_cpu = 1'b1;
        state_d = (grant_disp || grant_cpu) ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (vram.vram_ack) state_d = ST_CAPT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_cpu_q  <= 1'b0;
      disp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_disp || grant_cpu) owner_cpu_q <= grant_cpu;
      if (disp_done) disp_rdata_q <= vram.vram_rdata;
    end
  end

  // Request is issued combinationally from IDLE/CAPT to keep the 4-cycle cadence.
  assign vram.vram_req   = grant_disp | grant_cpu;
  assign vram.vram_wr    = grant_cpu & p_wr;
  assign vram.vram_addr  = grant_cpu ? p_addr : (grant_disp ? disp_addr : '0);
  assign vram.vram_wdata = p_wdata;

  assign disp_ack   = disp_done;
  assign disp_rdata = disp_done ? vram.vram_rdata : disp_rdata_q;

endmodule

// File: tb/tb_vdp_vram_arb.sv
// Directed bench for vdp_vram_arb with a 3-cycle SRAM controller model.
module tb_vdp_vram_arb;
  import vdp_arb_pkg::*;

  localparam int unsigned FL = 3;
  localparam int OP_DISP = 0, OP_CPU_RD = 1, OP_CPU_WR = 2;
  localparam int K_ADDR_LD = 0, K_DATA_WR = 1, K_DATA_RD = 2;

  typedef struct {
    int                 op;
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] data;
    logic [VRAM_DW-1:0] exp;
  } vec_t;

  logic               clk40m = 1'b0;
  logic               rst_n = 1'b0;
  logic               disp_req = 1'b0;
  logic [VRAM_AW-1:0] disp_addr = '0;
  logic               disp_ack;
  logic [VRAM_DW-1:0] disp_rdata;
  logic               cpu_addr_ld = 1'b0;
  logic [VRAM_AW-1:0] cpu_addr = '0;
  logic               cpu_rd_ahead = 1'b0;
  logic               cpu_data_wr = 1'b0;
  logic [VRAM_DW-1:0] cpu_wdata = '0;
  logic               cpu_data_rd = 1'b0;
  logic [VRAM_DW-1:0] cpu_rdata;
  logic               cpu_busy;
  logic               cpu_overrun;

  vdp_vram_arb_if vif ();

  vdp_vram_arb #(.FAIR_LIMIT(FL)) dut (
    .clk40m       (clk40m),
    .rst_n        (rst_n),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_ack     (disp_ack),
    .disp_rdata   (disp_rdata),
    .cpu_addr_ld  (cpu_addr_ld),
    .cpu_addr     (cpu_addr),
    .cpu_rd_ahead (cpu_rd_ahead),
    .cpu_data_wr  (cpu_data_wr),
    .cpu_wdata    (cpu_wdata),
    .cpu_data_rd  (cpu_data_rd),
    .cpu_rdata    (cpu_rdata),
    .cpu_busy     (cpu_busy),
    .cpu_overrun  (cpu_overrun),
    .vram         (vif)
  );

  always #5 clk40m = ~clk40m;

  // SRAM controller model: ack 3 cycles after req, read data the cycle after ack.
  logic [VRAM_DW-1:0] mem [0:16383];
  logic [2:0]         ack_sr;
  logic [VRAM_AW-1:0] rd_addr;
  logic [VRAM_AW-1:0] last_wr_addr;
  logic [VRAM_DW-1:0] last_wr_data;
  int                 n_wr = 0;

  assign vif.vram_ack = ack_sr[2];

  always @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      ack_sr         <= '0;
      vif.vram_rdata <= '0;
    end else begin
      ack_sr <= {ack_sr[1:0], vif.vram_req};
      if (vif.vram_req) rd_addr <= vif.vram_addr;
      if (ack_sr[2]) vif.vram_rdata <= mem[rd_addr];
    end
  end

  always @(posedge clk40m) begin
    if (rst_n && vif.vram_req && vif.vram_wr) begin
      n_wr         <= n_wr + 1;
      last_wr_addr <= vif.vram_addr;
      last_wr_data <= vif.vram_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk40m);
    #1;
  endtask

  task automatic disp_read(input logic [VRAM_AW-1:0] a, output logic [VRAM_DW-1:0] d,
                           output int lat);
    disp_req  = 1'b1;
    disp_addr = a;
    #1;
    check("disp_issue", {vif.vram_req, vif.vram_wr}, 2'b10);
    check("disp_issue_addr", vif.vram_addr, a);
    lat = 0;
    d   = '0;
    while (lat < 20) begin
      tick();
      lat++;
      if (disp_ack) begin
        d = disp_rdata;
        break;
      end
    end
    disp_req = 1'b0;
    tick();
  endtask

  task automatic cpu_op(input int kind, input logic [VRAM_AW-1:0] a, input logic rd,
                        input logic [VRAM_DW-1:0] wd, input logic exp_issue,
                        input logic [VRAM_AW-1:0] exp_addr, input logic exp_wr,
                        input string tag);
    int lat;
    cpu_addr_ld  = (kind == K_ADDR_LD);
    cpu_data_wr  = (kind == K_DATA_WR);
    cpu_data_rd  = (kind == K_DATA_RD);
    cpu_addr     = a;
    cpu_rd_ahead = rd;
    cpu_wdata    = wd;
    tick();
    cpu_addr_ld  = 1'b0;
    cpu_data_wr  = 1'b0;
    cpu_data_rd  = 1'b0;
    cpu_rd_ahead = 1'b0;
    if (exp_issue) begin
      check({tag, "_req"}, {vif.vram_req, vif.vram_wr, cpu_busy}, {1'b1, exp_wr, 1'b1});
      check({tag, "_addr"}, vif.vram_addr, exp_addr);
      lat = 1;
      while (cpu_busy && lat < 30) begin
        tick();
        lat++;
      end
      check({tag, "_busy_lat"}, lat, ACCESS_CYCLES + 2);
    end else begin
      check({tag, "_idle"}, {cpu_busy, vif.vram_req}, 2'b00);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vram"}, {vif.vram_req, vif.vram_wr, vif.vram_addr, vif.vram_wdata}, 0);
    check({tag, "_disp"}, {disp_ack, disp_rdata}, 0);
    check({tag, "_cpu"}, {cpu_rdata, cpu_busy, cpu_overrun}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t               vecs [6];
    logic [VRAM_DW-1:0] d;
    int                 lat, dgr, wcyc, n, w0;
    bit                 wseen;

    vecs[0] = '{OP_DISP,   14'h1234, 8'hA5, 8'hA5};
    vecs[1] = '{OP_DISP,   14'h0001, 8'h5F, 8'h5F};
    vecs[2] = '{OP_DISP,   14'h3FFF, 8'hFF, 8'hFF};
    vecs[3] = '{OP_CPU_RD, 14'h0ABC, 8'h96, 8'h96};
    vecs[4] = '{OP_CPU_WR, 14'h2001, 8'hC3, 8'hC3};
    vecs[5] = '{OP_DISP,   14'h2AAA, 8'h01, 8'h01};

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].op != OP_CPU_WR) mem[vecs[i].addr] = vecs[i].data;
      case (vecs[i].op)
        OP_DISP: begin
          disp_read(vecs[i].addr, d, lat);
          check($sformatf("vec%0d_disp_data", i), d, vecs[i].exp);
          check($sformatf("vec%0d_disp_lat", i), lat, ACCESS_CYCLES);
        end
        OP_CPU_RD: begin
          cpu_op(K_ADDR_LD, vecs[i].addr, 1'b1, '0, 1'b1, vecs[i].addr, 1'b0, "vec_rd");
          check($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].exp);
        end
        default: begin
          cpu_op(K_ADDR_LD, vecs[i].addr, 1'b0, '0, 1'b0, '0, 1'b0, "vec_ld");
          cpu_op(K_DATA_WR, '0, 1'b0, vecs[i].data, 1'b1, vecs[i].addr, 1'b1, "vec_wr");
          check($sformatf("vec%0d_wr_bus", i), {last_wr_addr, last_wr_data},
                {vecs[i].addr, vecs[i].exp});
        end
      endcase
    end

    // Write at the top of VRAM, then a read-ahead proves the register wrapped.
    mem[14'h0000] = 8'h3C;
    cpu_op(K_ADDR_LD, 14'h3FFF, 1'b0, '0, 1'b0, '0, 1'b0, "wrap_ld");
    cpu_op(K_DATA_WR, '0, 1'b0, 8'h5A, 1'b1, 14'h3FFF, 1'b1, "wrap_wr");
    check("wrap_wr_bus", {last_wr_addr, last_wr_data}, {14'h3FFF, 8'h5A});
    check("wrap_wdata_hold", vif.vram_wdata, 8'h5A);
    cpu_op(K_DATA_RD, '0, 1'b0, '0, 1'b1, 14'h0000, 1'b0, "wrap_rd");
    check("wrap_rdata", cpu_rdata, 8'h3C);

    // Read-ahead chain.
    mem[14'h0100] = 8'h11;
    mem[14'h0101] = 8'h22;
    mem[14'h0102] = 8'h33;
    cpu_op(K_ADDR_LD, 14'h0100, 1'b1, '0, 1'b1, 14'h0100, 1'b0, "ra_ld");
    check("ra_first", cpu_rdata, 8'h11);
    cpu_op(K_DATA_RD, '0, 1'b0, '0, 1'b1, 14'h0101, 1'b0, "ra_rd1");
    check("ra_second", cpu_rdata, 8'h22);
    cpu_op(K_DATA_RD, '0, 1'b0, '0, 1'b1, 14'h0102, 1'b0, "ra_rd2");
    check("ra_third", cpu_rdata, 8'h33);

    // Contention: display streams continuously, CPU write pended during slot 0.
    mem[14'h0400] = 8'h4D;
    cpu_op(K_ADDR_LD, 14'h0300, 1'b0, '0, 1'b0, '0, 1'b0, "cont_ld");
    disp_addr = 14'h0400;
    disp_req  = 1'b1;
    cpu_wdata = 8'h9E;
    dgr   = 0;
    wcyc  = -1;
    wseen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      cpu_data_wr = (c == 2);
      #1;
      if (vif.vram_req && vif.vram_wr) begin
        wseen = 1'b1;
        wcyc  = c;
      end else if (vif.vram_req && c > 2) begin
        dgr++;
      end
      if (wseen) break;
      tick();
    end
    cpu_data_wr = 1'b0;
`ifdef VDP_ARB_FAIR_EN
    check("fair_write_slot", wcyc, (FL + 1) * ACCESS_CYCLES);
    check("fair_disp_grants", dgr, FL);
    tick();
`else
    check("strict_no_write", {wseen, wcyc}, {1'b0, 32'hFFFF_FFFF});
    check("strict_disp_grants", dgr, 14);
`endif
    n = 0;
    while (!disp_ack && n < 20) begin
      tick();
      n++;
    end
    check("cont_drain_ack", disp_ack, 1'b1);
    check("cont_disp_data", disp_rdata, 8'h4D);
    disp_req = 1'b0;
`ifndef VDP_ARB_FAIR_EN
    #1;
    check("strict_write_after_drop", {vif.vram_req, vif.vram_wr, vif.vram_addr},
          {1'b1, 1'b1, 14'h0300});
`endif
    n = 0;
    while (cpu_busy && n < 30) begin
      tick();
      n++;
    end
    repeat (6) tick();
    check("cont_write_bus", {last_wr_addr, last_wr_data}, {14'h0300, 8'h9E});

    // Overrun: second write while busy must be dropped.
    cpu_op(K_ADDR_LD, 14'h0200, 1'b0, '0, 1'b0, '0, 1'b0, "ovr_ld");
    check("ovr_clear", cpu_overrun, 1'b0);
    w0 = n_wr;
    cpu_data_wr = 1'b1;
    cpu_wdata   = 8'h66;
    tick();
    cpu_data_wr = 1'b0;
    tick();
    cpu_data_wr = 1'b1;
    cpu_wdata   = 8'h77;
    tick();
    cpu_data_wr = 1'b0;
    check("ovr_flag", cpu_overrun, 1'b1);
    n = 0;
    while (cpu_busy && n < 30) begin
      tick();
      n++;
    end
    repeat (6) tick();
    check("ovr_one_write", n_wr - w0, 1);
    check("ovr_wr_bus", {last_wr_addr, last_wr_data}, {14'h0200, 8'h66});
    check("ovr_wdata_hold", vif.vram_wdata, 8'h66);
    check("ovr_sticky", cpu_overrun, 1'b1);

    // Reset asserted while a display read sits in WAIT.
    mem[14'h0555] = 8'hE7;
    disp_addr = 14'h0555;
    disp_req  = 1'b1;
    tick();
    tick();
    rst_n    = 1'b0;
    disp_req = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    disp_read(14'h0555, d, lat);
    check("rst_after_data", d, 8'hE7);
    check("rst_after_lat", lat, ACCESS_CYCLES);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
